// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead chunk per stage,
// registered carry between stages, valid/ready handshake with full-pipeline stall.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int STAGES = (BLOCK > 0) ? WIDTH / BLOCK : 1;

    if (BLOCK < 1 || WIDTH < 1 || (WIDTH % ((BLOCK > 0) ? BLOCK : 1)) != 0) begin : g_bad_params
        $fatal(1, "pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
    end

    // Two-level lookahead: every carry is a flat sum of generate/propagate products.
    // Returns {carry into chunk MSB, carry out of chunk, sum}.
    function automatic logic [BLOCK+1:0] cla_chunk(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             c0
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic [BLOCK-1:0] s;
        logic             term;
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            term = c0;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        s = a ^ b ^ c[BLOCK-1:0];
        return {c[BLOCK-1], c[BLOCK], s};
    endfunction

    logic adv;
    logic xfer;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~reset;
    assign xfer     = in_valid & in_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int SW = WIDTH - s * BLOCK;
        localparam int RW = (s + 1) * BLOCK;

        logic             v_d;
        logic             c_d;
        logic [SW-1:0]    a_src;
        logic [SW-1:0]    b_src;
        logic [BLOCK+1:0] chunk;
        logic [RW-1:0]    r_next;
        logic             vld_q;
        logic             c_q;
        logic [RW-1:0]    r_q;

        // Subtraction inverts B and the borrow once, here; later stages just add.
        if (s == 0) begin : g_head
            assign v_d    = xfer;
            assign a_src  = in_a;
            assign b_src  = in_b ^ {WIDTH{in_sub}};
            assign c_d    = in_cin ^ in_sub;
            assign r_next = chunk[BLOCK-1:0];
        end else begin : g_body
            assign v_d    = g_stage[s-1].vld_q;
            assign a_src  = g_stage[s-1].g_fwd.a_q;
            assign b_src  = g_stage[s-1].g_fwd.b_q;
            assign c_d    = g_stage[s-1].c_q;
            assign r_next = {chunk[BLOCK-1:0], g_stage[s-1].r_q};
        end

        assign chunk = cla_chunk(a_src[BLOCK-1:0], b_src[BLOCK-1:0], c_d);

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                r_q   <= '0;
            end else if (adv) begin
                vld_q <= v_d;
                c_q   <= chunk[BLOCK];
                r_q   <= r_next;
            end
        end

        // Only the operand bits still to be summed travel down the pipe.
        if (s < STAGES - 1) begin : g_fwd
            logic [SW-BLOCK-1:0] a_q;
            logic [SW-BLOCK-1:0] b_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[SW-1:BLOCK];
                    b_q <= b_src[SW-1:BLOCK];
                end
            end
        end

        if (s == STAGES - 1) begin : g_tail
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= chunk[BLOCK+1] ^ chunk[BLOCK];
                    zero_q <= ~|r_next;
                end
            end

            assign out_valid  = vld_q;
            assign out_result = r_q;
            assign out_cout   = c_q;
            assign out_ovf    = ovf_q;
            assign out_zero   = zero_q;
        end
    end
endmodule
